fp16_div_arbiter: RTL and testbench

FP16_DIV_ARBITER -- requirements
Module: fp16_div_arbiter

---
 rtl/fp16_div_arbiter.sv | 111 +++++++++++
 tb/tb_fp16_div_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_div_arbiter.sv
// Round-robin arbiter sharing one pipelined fp16 divider among N_REQ requesters.
// Latency: rsp_valid in the (DIV_LAT+1)th cycle after the accept cycle; div_a/div_b are driven from the accept edge.
// Backpressure: at most one req_ready per cycle, none while en=0 or in reset; responses cannot be stalled.
module fp16_div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DIV_LAT = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic [15:0]           div_a,
    output logic [15:0]           div_b,
    input  logic [15:0]           div_result,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [15:0]           rsp_data,
    output logic [4:0]            inflight,
    output logic                  busy
);
    // Index width covers the full 2..8 requester range.
    localparam int IW  = 3;
    // Tag stages: one per cycle between the accept edge and the result cycle.
    localparam int NST = DIV_LAT + 1;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner;
    logic          found;
    logic          accept;
    logic [15:0]   win_a;
    logic [15:0]   win_b;
    logic          tag_vld [NST];
    logic [IW-1:0] tag_idx [NST];
    logic          rsp_fire;
    logic [4:0]    inflight_q;

    // Rotating priority search: offsets scanned from farthest to nearest so the
    // requester closest after last_grant overwrites any other candidate.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (k == ((int'(last_grant) + i) % N_REQ) && req_valid[k]) begin
                    found  = 1'b1;
                    winner = IW'(k);
                end
            end
        end
    end

    // Grant decode and operand selection for the winning requester.
    always_comb begin
        accept    = found && en && rst_n;
        req_ready = '0;
        win_a     = 16'h0000;
        win_b     = 16'h0000;
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == IW'(k)) begin
                req_ready[k] = accept;
                win_a        = req_a[16*k +: 16];
                win_b        = req_b[16*k +: 16];
            end
        end
    end

    // Response strobe from the oldest tag; divider result passes through untouched.
    always_comb begin
        rsp_fire  = rst_n && tag_vld[NST-1];
        rsp_valid = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rsp_valid[k] = rsp_fire && (tag_idx[NST-1] == IW'(k));
        end
        rsp_data = div_result;
        inflight = inflight_q;
        busy     = rst_n && (inflight_q != 5'd0);
    end

    // Operand register, tag shift pipeline, grant pointer and in-flight counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= IW'(N_REQ - 1);
            div_a      <= 16'h0000;
            div_b      <= 16'h0000;
            inflight_q <= 5'd0;
            for (int s = 0; s < NST; s++) begin
                tag_vld[s] <= 1'b0;
                tag_idx[s] <= '0;
            end
        end else begin
            tag_vld[0] <= accept;
            tag_idx[0] <= winner;
            for (int s = 1; s < NST; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
            div_a <= accept ? win_a : 16'h0000;
            div_b <= accept ? win_b : 16'h0000;
            if (accept) begin
                last_grant <= winner;
            end
            case ({accept, rsp_fire})
                2'b10:   inflight_q <= inflight_q + 5'd1;
                2'b01:   inflight_q <= inflight_q - 5'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_div_arbiter.sv
// Testbench for fp16_div_arbiter: random and directed requests, scoreboard of expected responses.
// A stub divider with the agreed pipeline timing feeds div_result from div_a/div_b.
// Issue monitor predicts grants; response monitor checks order, data, timing and inflight.
module tb_fp16_div_arbiter;
    localparam int N_REQ   = 4;
    localparam int DIV_LAT = 14;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [16*N_REQ-1:0] req_a = '0;
    logic [16*N_REQ-1:0] req_b = '0;
    logic [15:0]         div_a;
    logic [15:0]         div_b;
    logic [15:0]         div_result;
    logic [N_REQ-1:0]    rsp_valid;
    logic [15:0]         rsp_data;
    logic [4:0]          inflight;
    logic                busy;

    fp16_div_arbiter #(.N_REQ(N_REQ), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .div_a(div_a), .div_b(div_b), .div_result(div_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Divider stand-in: exact results for the directed cases, a fixed mixing
    // function otherwise (the arbiter never inspects the value).
    function automatic logic [15:0] div_ref(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h4400 && b == 16'h4000) return 16'h4000;
        if (a == 16'h3C00 && b == 16'h0000) return 16'h7C00;
        if (a == 16'h0000 && b == 16'h0000) return 16'h7C01;
        return {a[7:0] ^ b[15:8], a[15:8] + b[7:0]};
    endfunction

    // Stub divider: samples div_a/div_b on the edge after they are loaded.
    logic [15:0] dpipe [DIV_LAT];
    always @(posedge clk) begin
        dpipe[0] <= div_ref(div_a, div_b);
        for (int i = 1; i < DIV_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign div_result = dpipe[DIV_LAT-1];

    typedef struct {
        int          idx;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   dut_peak = 0;

    // Issue monitor: reference round-robin, pushes expected responses on accept.
    initial begin : issue_mon
        int last_m;
        int win;
        int cand;
        int waitc [N_REQ];
        logic [N_REQ-1:0] exp_rdy;
        exp_t e;
        last_m = N_REQ - 1;
        for (int k = 0; k < N_REQ; k++) waitc[k] = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                last_m = N_REQ - 1;
                for (int k = 0; k < N_REQ; k++) waitc[k] = 0;
                check("ready_in_reset", 32'(req_ready), 32'd0);
            end else begin
                win = -1;
                if (en) begin
                    for (int i = 1; i <= N_REQ; i++) begin
                        cand = (last_m + i) % N_REQ;
                        if (win < 0 && req_valid[cand]) win = cand;
                    end
                end
                exp_rdy = '0;
                if (win >= 0) exp_rdy[win] = 1'b1;
                check("req_ready", 32'(req_ready), 32'(exp_rdy));
                for (int k = 0; k < N_REQ; k++) begin
                    if (req_valid[k] && req_ready[k]) grant_log.push_back(k);
                    if (req_valid[k] && en && !req_ready[k]) waitc[k]++;
                    else waitc[k] = 0;
                    if (req_valid[k] && en) check("fairness_wait", 32'(waitc[k] < N_REQ), 32'd1);
                end
                if (win >= 0) begin
                    e.idx  = win;
                    e.data = div_ref(req_a[16*win +: 16], req_b[16*win +: 16]);
                    e.due  = cyc + DIV_LAT + 1;
                    sb.push_back(e);
                    last_m = win;
                end
            end
        end
    end

    // Response monitor: pops the oldest expectation whenever a response appears.
    initial begin : rsp_mon
        exp_t e;
        logic [N_REQ-1:0] exp_oh;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
                check("busy_in_reset", 32'(busy), 32'd0);
                sb.delete();
            end else begin
                check("inflight", 32'(inflight), 32'(sb.size()));
                check("busy", 32'(busy), 32'(sb.size() != 0));
                if (int'(inflight) > dut_peak) dut_peak = int'(inflight);
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        check("spurious_rsp", 32'(rsp_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        exp_oh = '0;
                        exp_oh[e.idx] = 1'b1;
                        check("rsp_valid_idx", 32'(rsp_valid), 32'(exp_oh));
                        check("rsp_data", 32'(rsp_data), 32'(e.data));
                        check("rsp_cycle", 32'(cyc), 32'(e.due));
                    end
                end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    exp_oh = '0;
                    exp_oh[e.idx] = 1'b1;
                    check("missing_rsp", 32'(rsp_valid), 32'(exp_oh));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b);
        req_valid[k]      = 1'b1;
        req_a[16*k +: 16] = a;
        req_b[16*k +: 16] = b;
    endtask

    // Hold one request until granted, then release it after the accept edge.
    task automatic issue_one(input int k, input logic [15:0] a, input logic [15:0] b);
        int t;
        t = 0;
        set_req(k, a, b);
        #1;
        while (!req_ready[k] && t < 50) begin
            tick();
            #1;
            t++;
        end
        check("grant_timeout", 32'(t < 50), 32'd1);
        tick();
        req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            tick();
            t++;
        end
        check("drain_timeout", 32'(t < 200), 32'd1);
        tick(2);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int acc;
        int t;
        int exp_order [8];
        tick(3);
        rst_n = 1'b1;
        en    = 1'b1;
        check("reset_div_a", 32'(div_a), 32'd0);
        check("reset_div_b", 32'(div_b), 32'd0);
        check("reset_inflight", 32'(inflight), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Single op from requester 2: 4.0 / 2.0.
        issue_one(2, 16'h4400, 16'h4000);
        acc = cyc - 1;
        t = 0;
        @(negedge clk);
        while (rsp_valid == '0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("single_rsp_valid", 32'(rsp_valid), 32'b0100);
        check("single_rsp_data", 32'(rsp_data), 32'h4000);
        check("single_latency", 32'(cyc - acc), 32'(DIV_LAT + 1));
        tick();
        drain();

        // All four requesters for 8 cycles straight from reset.
        do_reset(2);
        grant_log.delete();
        dut_peak = 0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < N_REQ; k++) set_req(k, 16'($urandom), 16'($urandom));
            tick();
        end
        req_valid = '0;
        drain();
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        check("rr_grant_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_log.size()) check("rr_grant_order", 32'(grant_log[i]), 32'(exp_order[i]));
        end
        check("inflight_peak", 32'(dut_peak), 32'd8);

        // Special encodings pass through unmodified.
        issue_one(1, 16'h3C00, 16'h0000);
        issue_one(3, 16'h0000, 16'h0000);
        drain();

        // en low for 5 cycles with 3 operations in flight.
        issue_one(0, 16'($urandom), 16'($urandom));
        issue_one(1, 16'($urandom), 16'($urandom));
        issue_one(2, 16'($urandom), 16'($urandom));
        en = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("ready_while_en_low", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = '0;
        en = 1'b1;
        drain();

        // Reset mid-flight discards everything; requester 0 wins first afterwards.
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < N_REQ; k++) set_req(k, 16'($urandom), 16'($urandom));
            tick();
        end
        req_valid = '0;
        tick(6);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int k = 0; k < N_REQ; k++) set_req(k, 16'($urandom), 16'($urandom));
        #1;
        check("post_reset_inflight", 32'(inflight), 32'd0);
        check("post_reset_first_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        drain();

        // Randomised traffic with occasional en drops.
        for (int c = 0; c < 400; c++) begin
            req_valid = N_REQ'($urandom);
            en = ($urandom_range(0, 9) != 0);
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            tick();
        end
        req_valid = '0;
        en = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
